// File: rtl/pc_fetch_sequencer_if.sv
// ============================================================================
// Module      : pc_fetch_sequencer_if
// Description : Instruction-memory req/ack and decode valid/ready bundle used
//               by the fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_fetch_sequencer_if #(
    parameter int N = 32
);
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_ack;
    logic [N-1:0] imem_rdata;
    logic [N-1:0] instr;
    logic [N-1:0] instr_pc;
    logic         instr_valid;
    logic         instr_ready;

    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid,
        input  imem_ack, imem_rdata, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid,
        output imem_ack, imem_rdata, instr_ready
    );
endinterface

`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
// ============================================================================
// Module      : pc_fetch_sequencer
// Description : PC owner and fetch sequencer (BOOT/REQ/VALID); redirect
//               priority trap > jump > branch > PC+4. Optional macro
//               PC_ALIGN_CHECK_EN traps misaligned redirect targets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_sequencer #(
    parameter int          N            = 32,
    parameter logic [N-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [N-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              stall,
    input  wire logic              branch_taken,
    input  wire logic [N-1:0]      branch_target,
    input  wire logic              jump,
    input  wire logic [N-1:0]      jump_target,
    input  wire logic              trap,
    input  wire logic [N-1:0]      trap_target,
    pc_fetch_sequencer_if.master   bus,
    output logic [N-1:0]           pc,
    output logic                   misalign
);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;

    logic [1:0]   r_state;
    logic [1:0]   w_next_state;
    logic [N-1:0] r_pc;
    logic [N-1:0] r_instr;
    logic [N-1:0] r_instr_pc;
    logic         r_instr_valid;
    logic         r_pend;
    logic [N-1:0] r_pend_tgt;
    logic         w_redir;
    logic [N-1:0] w_sel;
    logic [N-1:0] w_tgt;

    assign w_redir = trap | jump | branch_taken;

    always_comb begin
        w_sel = branch_target;
        if (jump) w_sel = jump_target;
        if (trap) w_sel = trap_target;
    end

`ifdef PC_ALIGN_CHECK_EN
    logic w_mis;
    logic r_misalign;

    assign w_mis = w_redir && (w_sel[1:0] != 2'b00);
    assign w_tgt = w_mis ? TRAP_VECTOR : w_sel;

    // Pulse follows the cycle in which the misaligned redirect was captured.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_misalign <= 1'b0;
        else      r_misalign <= (r_state != S_BOOT) && w_mis;
    end
    assign misalign = r_misalign;
`else
    logic w_unused_trap_vector;

    assign w_unused_trap_vector = ^TRAP_VECTOR;
    assign w_tgt                = w_sel;
    assign misalign             = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_BOOT;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_BOOT:  w_next_state = S_REQ;
            S_REQ:   if (bus.imem_ack && !w_redir && !r_pend) w_next_state = S_VALID;
            S_VALID: if (w_redir || (bus.instr_ready && !stall)) w_next_state = S_REQ;
            default: w_next_state = S_BOOT;
        endcase
    end

    always_comb begin
        bus.imem_req = (r_state == S_REQ);
    end

    // A redirect seen while a fetch is outstanding is parked until the ack so
    // the memory sees a stable address for the whole request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc          <= RESET_VECTOR;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_pend        <= 1'b0;
            r_pend_tgt    <= '0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (bus.imem_ack) begin
                        if (w_redir) begin
                            r_pc   <= w_tgt;
                            r_pend <= 1'b0;
                        end else if (r_pend) begin
                            r_pc   <= r_pend_tgt;
                            r_pend <= 1'b0;
                        end else begin
                            r_instr       <= bus.imem_rdata;
                            r_instr_pc    <= r_pc;
                            r_instr_valid <= 1'b1;
                        end
                    end else if (w_redir) begin
                        r_pend_tgt <= w_tgt;
                        r_pend     <= 1'b1;
                    end
                end
                S_VALID: begin
                    if (w_redir) begin
                        r_instr_valid <= 1'b0;
                        r_pc          <= w_tgt;
                    end else if (bus.instr_ready && !stall) begin
                        r_instr_valid <= 1'b0;
                        r_pc          <= r_pc + N'(4);
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc              = r_pc;
    assign bus.imem_addr   = r_pc;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = r_instr_valid;

endmodule

`default_nettype wire
